// File: rtl/addr_mode_fetcher.sv
// 6502 instruction fetcher: reads opcode and operands over a req/ack port,
// decodes the addressing mode and resolves the effective address.
module addr_mode_fetcher #(
    parameter logic [15:0] RESET_PC    = 16'h0600,
    parameter logic        ZP_WRAP     = 1'b1,
    parameter logic        JMP_IND_BUG = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] pc_in,
    input  logic [7:0]  x_in,
    input  logic [7:0]  y_in,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic [7:0]  opcode,
    output logic [7:0]  operand,
    output logic [3:0]  mode,
    output logic [15:0] ea,
    output logic        page_cross,
    output logic [15:0] pc_next
);

    typedef enum logic [2:0] {
        S_IDLE, S_OPC, S_OP1, S_OP2, S_PTR_LO, S_PTR_HI, S_DONE
    } state_t;

    localparam logic [3:0] M_IMPL  = 4'd0;
    localparam logic [3:0] M_IMM   = 4'd1;
    localparam logic [3:0] M_ZPG   = 4'd2;
    localparam logic [3:0] M_ZPG_X = 4'd3;
    localparam logic [3:0] M_ZPG_Y = 4'd4;
    localparam logic [3:0] M_ABS   = 4'd5;
    localparam logic [3:0] M_ABS_X = 4'd6;
    localparam logic [3:0] M_ABS_Y = 4'd7;
    localparam logic [3:0] M_X_IND = 4'd8;
    localparam logic [3:0] M_IND_Y = 4'd9;
    localparam logic [3:0] M_REL   = 4'd10;
    localparam logic [3:0] M_IND   = 4'd11;

    function automatic logic [3:0] decode_mode(input logic [7:0] op);
        logic [3:0] m;
        m = M_IMPL;
        if (op[1:0] == 2'b01) begin
            case (op[4:2])
                3'd0:    m = M_X_IND;
                3'd1:    m = M_ZPG;
                3'd2:    m = M_IMM;
                3'd3:    m = M_ABS;
                3'd4:    m = M_IND_Y;
                3'd5:    m = M_ZPG_X;
                3'd6:    m = M_ABS_Y;
                default: m = M_ABS_X;
            endcase
        end else if (op[1:0] != 2'b11) begin
            case (op[4:2])
                3'd0:    m = op[7] ? M_IMM : M_IMPL;
                3'd1:    m = M_ZPG;
                3'd3:    m = M_ABS;
                3'd4:    m = (op[4:0] == 5'b10000) ? M_REL : M_IMPL;
                3'd5:    m = M_ZPG_X;
                3'd7:    m = M_ABS_X;
                default: m = M_IMPL;
            endcase
        end
        // Irregular opcodes that the column/row pattern gets wrong
        case (op)
            8'h96, 8'hB6:        m = M_ZPG_Y;
            8'hBE:               m = M_ABS_Y;
            8'h20:               m = M_ABS;
            8'h6C:               m = M_IND;
            8'h00, 8'h40, 8'h60: m = M_IMPL;
            default:             ;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] instr_len(input logic [3:0] m);
        case (m)
            M_IMPL:                        return 2'd1;
            M_ABS, M_ABS_X, M_ABS_Y, M_IND: return 2'd3;
            default:                       return 2'd2;
        endcase
    endfunction

    function automatic logic [15:0] ptr_hi_addr(input logic [3:0] m, input logic [15:0] p);
        if (m == M_IND)
            return JMP_IND_BUG ? {p[15:8], p[7:0] + 8'd1} : p + 16'd1;
        return ZP_WRAP ? {8'h00, p[7:0] + 8'd1} : p + 16'd1;
    endfunction

    function automatic logic [15:0] rel_target(input logic [15:0] base, input logic signed [7:0] off);
        logic signed [15:0] off_w;
        off_w = {{8{off[7]}}, off};
        return base + off_w;
    endfunction

    state_t      state;
    logic [15:0] pc_base;
    logic [7:0]  opc_r, op1_r, op2_r, lo_r, hi_r;
    logic [3:0]  mode_r;
    logic [15:0] ptr_r;

    logic        ack;
    logic [3:0]  dec_mode;
    logic [7:0]  xptr;
    logic [15:0] hi_addr;

    assign ack      = mem_ack & mem_rd;
    assign dec_mode = decode_mode(mem_rdata);
    assign xptr     = mem_rdata + x_in;
    assign hi_addr  = ptr_hi_addr(mode_r, ptr_r);

    logic [7:0]  idx;
    logic [8:0]  lo_sum;
    logic [15:0] pcn_calc, ea_calc;
    logic        pc_calc;

    always_comb begin
        idx      = (mode_r == M_ZPG_Y || mode_r == M_ABS_Y) ? y_in : x_in;
        lo_sum   = {1'b0, op1_r} + {1'b0, idx};
        pcn_calc = pc_base + {14'd0, instr_len(mode_r)};
        ea_calc  = 16'h0000;
        pc_calc  = 1'b0;
        case (mode_r)
            M_ZPG:            ea_calc = {8'h00, op1_r};
            M_ZPG_X, M_ZPG_Y: ea_calc = ZP_WRAP ? {8'h00, lo_sum[7:0]} : {7'h00, lo_sum};
            M_ABS:            ea_calc = {op2_r, op1_r};
            M_ABS_X, M_ABS_Y: begin
                ea_calc = {op2_r, op1_r} + {8'h00, idx};
                pc_calc = (ea_calc[15:8] != op2_r);
            end
            M_X_IND, M_IND:   ea_calc = {hi_r, lo_r};
            M_IND_Y: begin
                ea_calc = {hi_r, lo_r} + {8'h00, y_in};
                pc_calc = (ea_calc[15:8] != hi_r);
            end
            M_REL: begin
                ea_calc = rel_target(pcn_calc, op1_r);
                pc_calc = (ea_calc[15:8] != pcn_calc[15:8]);
            end
            default:          ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            mem_rd     <= 1'b0;
            mem_addr   <= 16'h0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            opcode     <= 8'h00;
            operand    <= 8'h00;
            mode       <= 4'd0;
            ea         <= 16'h0000;
            page_cross <= 1'b0;
            pc_next    <= RESET_PC;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    pc_base  <= pc_in;
                    mem_addr <= pc_in;
                    mem_rd   <= 1'b1;
                    busy     <= 1'b1;
                    state    <= S_OPC;
                end
                S_OPC: if (ack) begin
                    opc_r  <= mem_rdata;
                    mode_r <= dec_mode;
                    if (dec_mode == M_IMPL) begin
                        mem_rd <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        mem_addr <= pc_base + 16'd1;
                        state    <= S_OP1;
                    end
                end
                S_OP1: if (ack) begin
                    op1_r <= mem_rdata;
                    case (mode_r)
                        M_ABS, M_ABS_X, M_ABS_Y, M_IND: begin
                            mem_addr <= pc_base + 16'd2;
                            state    <= S_OP2;
                        end
                        M_X_IND: begin
                            ptr_r    <= {8'h00, xptr};
                            mem_addr <= {8'h00, xptr};
                            state    <= S_PTR_LO;
                        end
                        M_IND_Y: begin
                            ptr_r    <= {8'h00, mem_rdata};
                            mem_addr <= {8'h00, mem_rdata};
                            state    <= S_PTR_LO;
                        end
                        default: begin
                            mem_rd <= 1'b0;
                            state  <= S_DONE;
                        end
                    endcase
                end
                S_OP2: if (ack) begin
                    op2_r <= mem_rdata;
                    if (mode_r == M_IND) begin
                        ptr_r    <= {mem_rdata, op1_r};
                        mem_addr <= {mem_rdata, op1_r};
                        state    <= S_PTR_LO;
                    end else begin
                        mem_rd <= 1'b0;
                        state  <= S_DONE;
                    end
                end
                S_PTR_LO: if (ack) begin
                    lo_r     <= mem_rdata;
                    mem_addr <= hi_addr;
                    state    <= S_PTR_HI;
                end
                S_PTR_HI: if (ack) begin
                    hi_r   <= mem_rdata;
                    mem_rd <= 1'b0;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    opcode     <= opc_r;
                    operand    <= op1_r;
                    mode       <= mode_r;
                    ea         <= ea_calc;
                    page_cross <= pc_calc;
                    pc_next    <= pcn_calc;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addr_mode_fetcher.sv
// Bench for addr_mode_fetcher: two instances (default and non-wrapping / fixed JMP)
// share one memory image; vectors are queued as expectations and checked on done.
module tb_addr_mode_fetcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start;
    logic [15:0] pc_in;
    logic [7:0]  x_in, y_in;
    logic [7:0]  mem [0:65535];
    int          wait_n;

    logic [15:0] a_addr, b_addr, a_ea, b_ea, a_pcn, b_pcn;
    logic        a_rd, b_rd, a_ack, b_ack, a_busy, b_busy, a_done, b_done, a_pc, b_pc;
    logic [7:0]  a_rdata, b_rdata, a_opc, b_opc, a_opr, b_opr;
    logic [3:0]  a_mode, b_mode;
    int          a_wc, b_wc;

    assign a_rdata = mem[a_addr];
    assign b_rdata = mem[b_addr];
    assign a_ack   = (a_wc >= wait_n);
    assign b_ack   = (b_wc >= wait_n);

    always @(posedge clk) a_wc <= (a_rd && !a_ack) ? a_wc + 1 : 0;
    always @(posedge clk) b_wc <= (b_rd && !b_ack) ? b_wc + 1 : 0;

    addr_mode_fetcher dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .pc_in(pc_in), .x_in(x_in), .y_in(y_in),
        .mem_addr(a_addr), .mem_rd(a_rd), .mem_rdata(a_rdata), .mem_ack(a_ack),
        .busy(a_busy), .done(a_done), .opcode(a_opc), .operand(a_opr), .mode(a_mode),
        .ea(a_ea), .page_cross(a_pc), .pc_next(a_pcn)
    );

    addr_mode_fetcher #(.ZP_WRAP(1'b0), .JMP_IND_BUG(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .pc_in(pc_in), .x_in(x_in), .y_in(y_in),
        .mem_addr(b_addr), .mem_rd(b_rd), .mem_rdata(b_rdata), .mem_ack(b_ack),
        .busy(b_busy), .done(b_done), .opcode(b_opc), .operand(b_opr), .mode(b_mode),
        .ea(b_ea), .page_cross(b_pc), .pc_next(b_pcn)
    );

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [7:0]  b0, b1, b2, x, y;
        int          wt;
        logic [15:0] m0a, m1a, m2a;
        logic [7:0]  m0d, m1d, m2d;
        logic [3:0]  md;
        logic [7:0]  opr;
        logic        chk_ea;
        logic [15:0] ea_a, ea_b;
        logic        pcr;
        logic [15:0] pcn;
        int          lat;
        bit          poke;
    } vec_t;

    localparam logic [15:0] F = 16'hFFF0;

    vec_t vt[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(string nm, logic [15:0] pc, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                                logic [7:0] x, logic [7:0] y, int wt,
                                logic [15:0] m0a, logic [7:0] m0d, logic [15:0] m1a, logic [7:0] m1d,
                                logic [15:0] m2a, logic [7:0] m2d, logic [3:0] md, logic [7:0] opr,
                                logic chk_ea, logic [15:0] ea_a, logic [15:0] ea_b, logic pcr,
                                logic [15:0] pcn, int lat, bit poke);
        vec_t v;
        v.name = nm; v.pc = pc; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.x = x; v.y = y; v.wt = wt;
        v.m0a = m0a; v.m0d = m0d; v.m1a = m1a; v.m1d = m1d; v.m2a = m2a; v.m2d = m2d;
        v.md = md; v.opr = opr; v.chk_ea = chk_ea; v.ea_a = ea_a; v.ea_b = ea_b;
        v.pcr = pcr; v.pcn = pcn; v.lat = lat; v.poke = poke;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   n;
        bit   seen;
        vec_t e;
        mem[v.pc] = v.b0;
        mem[v.pc + 16'd1] = v.b1;
        mem[v.pc + 16'd2] = v.b2;
        mem[v.m0a] = v.m0d;
        mem[v.m1a] = v.m1d;
        mem[v.m2a] = v.m2d;
        pc_in = v.pc; x_in = v.x; y_in = v.y; wait_n = v.wt;
        @(negedge clk);
        start = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            if (v.poke && n == 0) begin start = 1'b1; pc_in = 16'h0700; end
            @(posedge clk);
            n++;
            #1;
            if (v.poke && n == 1) start = 1'b0;
            if (a_done) seen = 1'b1;
        end
        e = sb.pop_front();
        if (!seen) begin
            chk({e.name, ".timeout"}, 32'd0, 32'd1);
        end else begin
            chk({e.name, ".latency"}, n, e.lat);
            chk({e.name, ".b_done"}, b_done, 1'b1);
            chk({e.name, ".busy"}, a_busy, 1'b0);
            chk({e.name, ".opcode"}, a_opc, e.b0);
            chk({e.name, ".mode"}, a_mode, e.md);
            chk({e.name, ".b_mode"}, b_mode, e.md);
            if (e.md != 4'd0) chk({e.name, ".operand"}, a_opr, e.opr);
            if (e.chk_ea) begin
                chk({e.name, ".ea"}, a_ea, e.ea_a);
                chk({e.name, ".b_ea"}, b_ea, e.ea_b);
            end
            chk({e.name, ".page_cross"}, a_pc, e.pcr);
            chk({e.name, ".b_page_cross"}, b_pc, e.pcr);
            chk({e.name, ".pc_next"}, a_pcn, e.pcn);
            chk({e.name, ".b_pc_next"}, b_pcn, e.pcn);
        end
        @(posedge clk);
        #1 chk({e.name, ".done_pulse"}, a_done, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, n1, n2, dcnt;
        reset_n = 1'b0; start = 1'b0; pc_in = 16'h0; x_in = 8'h0; y_in = 8'h0; wait_n = 0;

        vt.push_back(mk("lda_imm",     16'h0600, 8'hA9, 8'h42, 8'h00, 8'h00, 8'h00, 0, F, 8'h0, F, 8'h0, F, 8'h0, 4'd1, 8'h42, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0602, 3, 1'b0));
        vt.push_back(mk("lda_absx",    16'h0600, 8'hBD, 8'hF0, 8'h12, 8'h20, 8'h00, 0, F, 8'h0, F, 8'h0, F, 8'h0, 4'd6, 8'hF0, 1'b1, 16'h1310, 16'h1310, 1'b1, 16'h0603, 4, 1'b0));
        vt.push_back(mk("lda_absx_w2", 16'h0600, 8'hBD, 8'hF0, 8'h12, 8'h20, 8'h00, 2, F, 8'h0, F, 8'h0, F, 8'h0, 4'd6, 8'hF0, 1'b1, 16'h1310, 16'h1310, 1'b1, 16'h0603, 10, 1'b0));
        vt.push_back(mk("lda_xind",    16'h0600, 8'hA1, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 16'h00FF, 8'h34, 16'h0000, 8'h12, 16'h0100, 8'h56, 4'd8, 8'hFF, 1'b1, 16'h1234, 16'h5634, 1'b0, 16'h0602, 5, 1'b0));
        vt.push_back(mk("jmp_ind",     16'h0600, 8'h6C, 8'hFF, 8'h10, 8'h00, 8'h00, 0, 16'h10FF, 8'h00, 16'h1000, 8'h80, 16'h1100, 8'h90, 4'd11, 8'hFF, 1'b1, 16'h8000, 16'h9000, 1'b0, 16'h0603, 6, 1'b0));
        vt.push_back(mk("bne_back",    16'h0650, 8'hD0, 8'h80, 8'h00, 8'h00, 8'h00, 0, F, 8'h0, F, 8'h0, F, 8'h0, 4'd10, 8'h80, 1'b1, 16'h05D2, 16'h05D2, 1'b1, 16'h0652, 3, 1'b0));
        vt.push_back(mk("nop",         16'h0600, 8'hEA, 8'h00, 8'h00, 8'h00, 8'h00, 0, F, 8'h0, F, 8'h0, F, 8'h0, 4'd0, 8'h00, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0601, 2, 1'b0));
        vt.push_back(mk("ldx_zpy",     16'h0600, 8'hB6, 8'h80, 8'h00, 8'h00, 8'h90, 0, F, 8'h0, F, 8'h0, F, 8'h0, 4'd4, 8'h80, 1'b1, 16'h0010, 16'h0110, 1'b0, 16'h0602, 3, 1'b0));
        vt.push_back(mk("lda_indy",    16'h0600, 8'hB1, 8'h40, 8'h00, 8'h00, 8'h10, 0, 16'h0040, 8'hF8, 16'h0041, 8'h20, F, 8'h0, 4'd9, 8'h40, 1'b1, 16'h2108, 16'h2108, 1'b1, 16'h0602, 5, 1'b0));
        vt.push_back(mk("jsr",         16'h0700, 8'h20, 8'h34, 8'h12, 8'h00, 8'h00, 0, F, 8'h0, F, 8'h0, F, 8'h0, 4'd5, 8'h34, 1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0703, 4, 1'b0));
        vt.push_back(mk("sta_zp",      16'h0600, 8'h85, 8'h44, 8'h00, 8'h00, 8'h00, 0, F, 8'h0, F, 8'h0, F, 8'h0, 4'd2, 8'h44, 1'b1, 16'h0044, 16'h0044, 1'b0, 16'h0602, 3, 1'b0));
        vt.push_back(mk("lda_absy_w1", 16'h0600, 8'hB9, 8'h00, 8'h30, 8'h00, 8'h05, 1, F, 8'h0, F, 8'h0, F, 8'h0, 4'd7, 8'h00, 1'b1, 16'h3005, 16'h3005, 1'b0, 16'h0603, 7, 1'b0));
        vt.push_back(mk("pc_wrap",     16'hFFFF, 8'hA9, 8'h77, 8'h00, 8'h00, 8'h00, 0, F, 8'h0, F, 8'h0, F, 8'h0, 4'd1, 8'h77, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0001, 3, 1'b0));
        vt.push_back(mk("rts",         16'h0600, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 0, F, 8'h0, F, 8'h0, F, 8'h0, 4'd0, 8'h00, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0601, 2, 1'b0));
        vt.push_back(mk("lda_zpx",     16'h0600, 8'hB5, 8'hF0, 8'h00, 8'h20, 8'h00, 0, F, 8'h0, F, 8'h0, F, 8'h0, 4'd3, 8'hF0, 1'b1, 16'h0010, 16'h0110, 1'b0, 16'h0602, 3, 1'b0));
        vt.push_back(mk("bpl_fwd",     16'h0600, 8'h10, 8'h05, 8'h00, 8'h00, 8'h00, 0, F, 8'h0, F, 8'h0, F, 8'h0, 4'd10, 8'h05, 1'b1, 16'h0607, 16'h0607, 1'b0, 16'h0602, 3, 1'b0));
        vt.push_back(mk("abs_poke",    16'h0600, 8'hAD, 8'h00, 8'h20, 8'h00, 8'h00, 0, F, 8'h0, F, 8'h0, F, 8'h0, 4'd5, 8'h00, 1'b1, 16'h2000, 16'h2000, 1'b0, 16'h0603, 4, 1'b1));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.mem_rd", a_rd, 1'b0);
        chk("rst.mem_addr", a_addr, 16'h0);
        chk("rst.busy", a_busy, 1'b0);
        chk("rst.done", a_done, 1'b0);
        chk("rst.opcode", a_opc, 8'h0);
        chk("rst.operand", a_opr, 8'h0);
        chk("rst.mode", a_mode, 4'd0);
        chk("rst.ea", a_ea, 16'h0);
        chk("rst.page_cross", a_pc, 1'b0);
        chk("rst.pc_next", a_pcn, 16'h0600);
        chk("rst.b_pc_next", b_pcn, 16'h0600);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vt[i]) run_vec(vt[i]);

        // Reset during OP2 of an absolute fetch
        mem[16'h0600] = 8'hAD; mem[16'h0601] = 8'h00; mem[16'h0602] = 8'h20;
        pc_in = 16'h0600; wait_n = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("midrst.busy_opc", a_busy, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst.op2_addr", a_addr, 16'h0602);
        chk("midrst.op2_rd", a_rd, 1'b1);
        @(negedge clk); reset_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst.mem_rd", a_rd, 1'b0);
        chk("midrst.busy", a_busy, 1'b0);
        chk("midrst.done", a_done, 1'b0);
        chk("midrst.pc_next", a_pcn, 16'h0600);
        @(negedge clk); reset_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (a_done || a_busy) dcnt++;
        end
        chk("midrst.no_done", dcnt, 0);

        // start held high: back-to-back fetches of a one-byte instruction
        mem[16'h0600] = 8'hEA;
        pc_in = 16'h0600; wait_n = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        n = 0; n1 = -1; n2 = -1;
        while (n2 < 0 && n < 40) begin
            @(posedge clk); n++; #1;
            if (a_done) begin
                if (n1 < 0) n1 = n;
                else begin n2 = n; start = 1'b0; end
            end
        end
        start = 1'b0;
        chk("hold.first_done", n1, 2);
        chk("hold.second_done", n2, 5);
        chk("hold.pc_next", a_pcn, 16'h0601);
        repeat (4) @(posedge clk);
        #1 chk("hold.idle", a_busy, 1'b0);

        // Recovery fetch after the reset sequence
        run_vec(vt[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
